// File: rtl/alu_fdr_ir.sv
// alu_fdr_ir: execute-stage slice of the CPU datapath.
//   Combinational 32-bit ALU (ARM-style data-processing opcodes plus
//   control-unit auxiliary opcodes), a 4-bit flag register (FDR) that
//   captures N/Z/C/V on FRLd, and the 32-bit instruction register (IR)
//   that latches memory read data on IRLd.
// Ports:
//   CLK, CLR         clock; synchronous active-high clear of FDR and IR
//   A, B, OP, CIN    ALU operands, 5-bit opcode, carry-in
//   FRLd, IRLd       load enables for FDR and IR
//   IR_IN            memory data to latch into IR
//   RESULT, FLAG_*   combinational ALU result and live flags
//   FDR_OUT          registered flags {N,Z,C,V}
//   IR_OUT           registered instruction
module alu_fdr_ir (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  OP,
    input  logic        CIN,
    input  logic        FRLd,
    input  logic        IRLd,
    input  logic [31:0] IR_IN,
    output logic [31:0] RESULT,
    output logic        FLAG_N,
    output logic        FLAG_Z,
    output logic        FLAG_C,
    output logic        FLAG_V,
    output logic [3:0]  FDR_OUT,
    output logic [31:0] IR_OUT
);

    // Every add/subtract form is x + y + k on one adder; subtraction
    // feeds the inverted subtrahend so C comes out as NOT borrow.
    logic [31:0] add_x, add_y, logic_res;
    logic [2:0]  add_k;
    logic        arith;
    logic [32:0] usum;
    logic [1:0]  shi;
    logic        c_flag, v_flag;

    always_comb begin
        add_x     = A;
        add_y     = B;
        add_k     = 3'd0;
        arith     = 1'b0;
        logic_res = B;
        case (OP)
            5'b00000, 5'b01000: logic_res = A & B;        // AND, TST
            5'b00001, 5'b01001: logic_res = A ^ B;        // EOR, TEQ
            5'b00010, 5'b01010: begin                     // SUB, CMP
                arith = 1'b1; add_y = ~B; add_k = 3'd1;
            end
            5'b00011: begin                               // RSB
                arith = 1'b1; add_x = B; add_y = ~A; add_k = 3'd1;
            end
            5'b00100, 5'b01011, 5'b10010: arith = 1'b1;   // ADD, CMN, aux A+B
            5'b00101: begin                               // ADC
                arith = 1'b1; add_k = {2'b00, CIN};
            end
            5'b00110: begin                               // SBC
                arith = 1'b1; add_y = ~B; add_k = {2'b00, CIN};
            end
            5'b00111: begin                               // RSC
                arith = 1'b1; add_x = B; add_y = ~A; add_k = {2'b00, CIN};
            end
            5'b01100: logic_res = A | B;                  // ORR
            5'b01101: logic_res = B;                      // MOV
            5'b01110: logic_res = A & ~B;                 // BIC
            5'b01111: logic_res = ~B;                     // MVN
            5'b10000: begin                               // PC + 4
                arith = 1'b1; add_y = 32'h0; add_k = 3'd4;
            end
            5'b10001: begin                               // A + B + 4
                arith = 1'b1; add_k = 3'd4;
            end
            5'b10011: logic_res = A;                      // pass A
            default:  logic_res = B;                      // pass B
        endcase
    end

    assign usum = {1'b0, add_x} + {1'b0, add_y} + {30'b0, add_k};

    // Upper two bits of the sign-extended sum: sign bits of both operands
    // plus the carry into bit 32. The result fits in 32 signed bits only
    // when both match the result sign; this also covers the +4 forms.
    assign shi    = {add_x[31], add_x[31]} + {add_y[31], add_y[31]} + {1'b0, usum[32]};
    assign c_flag = arith ? usum[32] : CIN;
    assign v_flag = arith & (shi != {usum[31], usum[31]});

    assign RESULT = arith ? usum[31:0] : logic_res;
    assign FLAG_N = RESULT[31];
    assign FLAG_Z = (RESULT == 32'h0);
    assign FLAG_C = c_flag;
    assign FLAG_V = v_flag;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            FDR_OUT <= 4'b0000;
            IR_OUT  <= 32'h0;
        end else begin
            if (FRLd) FDR_OUT <= {FLAG_N, FLAG_Z, FLAG_C, FLAG_V};
            if (IRLd) IR_OUT  <= IR_IN;
        end
    end

endmodule

// File: tb/tb_alu_fdr_ir.sv
module tb_alu_fdr_ir;

    logic        CLK = 1'b0;
    logic        CLR, CIN, FRLd, IRLd;
    logic [31:0] A, B, IR_IN;
    logic [4:0]  OP;
    logic [31:0] RESULT, IR_OUT;
    logic        FLAG_N, FLAG_Z, FLAG_C, FLAG_V;
    logic [3:0]  FDR_OUT;

    alu_fdr_ir dut (
        .CLK(CLK), .CLR(CLR), .A(A), .B(B), .OP(OP), .CIN(CIN),
        .FRLd(FRLd), .IRLd(IRLd), .IR_IN(IR_IN),
        .RESULT(RESULT), .FLAG_N(FLAG_N), .FLAG_Z(FLAG_Z),
        .FLAG_C(FLAG_C), .FLAG_V(FLAG_V),
        .FDR_OUT(FDR_OUT), .IR_OUT(IR_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        clr, frld, irld, cin;
        logic [31:0] a, b, ir_in;
        logic [4:0]  op;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {N,Z,C,V}
        logic [3:0]  fdr;
        logic [31:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   drive_done = 0;

    // Reference ALU from arithmetic on wide integers: unsigned 64-bit sum
    // gives RESULT and carry (bit 32), exact signed value gives overflow.
    function automatic exp_t alu_model(input logic [31:0] a, b,
                                       input logic [4:0] op, input logic cin);
        exp_t        e;
        logic [63:0] u;
        longint      s, sa, sb;
        logic [31:0] na, nb, r;
        bit          arith;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        na = ~a;
        nb = ~b;
        arith = 1;
        u = 0;
        s = 0;
        r = 0;
        case (op)
            5'd2, 5'd10:         begin u = 64'(a) + 64'(nb) + 64'd1; s = sa - sb; end
            5'd3:                begin u = 64'(b) + 64'(na) + 64'd1; s = sb - sa; end
            5'd4, 5'd11, 5'd18:  begin u = 64'(a) + 64'(b); s = sa + sb; end
            5'd5:                begin u = 64'(a) + 64'(b) + 64'(cin); s = sa + sb + longint'(cin); end
            5'd6:                begin u = 64'(a) + 64'(nb) + 64'(cin); s = sa - sb - longint'(!cin); end
            5'd7:                begin u = 64'(b) + 64'(na) + 64'(cin); s = sb - sa - longint'(!cin); end
            5'd16:               begin u = 64'(a) + 64'd4; s = sa + 4; end
            5'd17:               begin u = 64'(a) + 64'(b) + 64'd4; s = sa + sb + 4; end
            default: begin
                arith = 0;
                case (op)
                    5'd0, 5'd8:  r = a & b;
                    5'd1, 5'd9:  r = a ^ b;
                    5'd12:       r = a | b;
                    5'd14:       r = a & nb;
                    5'd15:       r = nb;
                    5'd19:       r = a;
                    default:     r = b;
                endcase
            end
        endcase
        if (arith) begin
            e.res = u[31:0];
            e.flags = {e.res[31], e.res == 0, u[32],
                       (s > 64'sd2147483647) || (s < -64'sd2147483648)};
        end else begin
            e.res = r;
            e.flags = {r[31], r == 0, cin, 1'b0};
        end
        e.fdr = 0;
        e.ir = 0;
        return e;
    endfunction

    function automatic vec_t mk(input logic clr, frld, irld,
                                input logic [4:0] op, input logic [31:0] a, b,
                                input logic cin, input logic [31:0] ir_in);
        vec_t v;
        v.clr = clr; v.frld = frld; v.irld = irld; v.op = op;
        v.a = a; v.b = b; v.cin = cin; v.ir_in = ir_in;
        return v;
    endfunction

    // Driver: applies one vector per cycle and pushes what the DUT must
    // show before the next edge; the model's registers advance on each edge.
    initial begin : driver
        vec_t        vl[$];
        vec_t        cur;
        exp_t        e;
        logic [3:0]  fdr_m;
        logic [31:0] ir_m;

        vl.push_back(mk(1,1,1, 5'b00100, 32'h7FFFFFFF, 32'h1, 1, 32'hDEADBEEF)); // reset w/ loads
        vl.push_back(mk(0,1,0, 5'b00100, 32'h7FFFFFFF, 32'h1, 0, 32'h0));        // ADD overflow
        vl.push_back(mk(0,0,0, 5'b01010, 32'h5, 32'h5, 0, 32'h0));               // CMP equal, no load
        vl.push_back(mk(0,1,0, 5'b00101, 32'hFFFFFFFF, 32'h0, 1, 32'h0));        // ADC
        vl.push_back(mk(0,1,0, 5'b00110, 32'h5, 32'h3, 0, 32'h0));               // SBC
        vl.push_back(mk(0,1,0, 5'b01110, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'h0)); // BIC
        vl.push_back(mk(0,0,0, 5'b01111, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0)); // MVN
        vl.push_back(mk(0,0,1, 5'b10000, 32'h10, 32'h0, 0, 32'hE2811001));       // PC+4, IR load
        vl.push_back(mk(0,0,0, 5'b10001, 32'h7FFFFFFE, 32'h7FFFFFFE, 0, 32'h12345678)); // IR hold
        vl.push_back(mk(0,1,1, 5'b00011, 32'h1, 32'h0, 0, 32'hCAFEF00D));        // RSB
        vl.push_back(mk(1,1,1, 5'b00111, 32'h0, 32'h80000000, 1, 32'h55AA55AA)); // clr overrides
        vl.push_back(mk(0,0,0, 5'b10011, 32'hA5A5A5A5, 32'h0, 1, 32'h0));
        for (int i = 0; i < 400; i++) begin
            cur.clr   = ($urandom_range(0, 15) == 0);
            cur.frld  = $urandom_range(0, 1);
            cur.irld  = $urandom_range(0, 1);
            cur.op    = 5'($urandom_range(0, 31));
            cur.cin   = $urandom_range(0, 1);
            cur.a     = $urandom();
            cur.b     = $urandom();
            cur.ir_in = $urandom();
            case ($urandom_range(0, 5))
                0: cur.a = 32'h7FFFFFFF;
                1: cur.b = cur.a;
                2: cur.a = 32'hFFFFFFFF;
                3: cur.b = 32'h80000000;
                default: ;
            endcase
            vl.push_back(cur);
        end

        CLR = 1; FRLd = 0; IRLd = 0; A = 0; B = 0; OP = 0; CIN = 0; IR_IN = 0;
        @(posedge CLK);
        fdr_m = 0;
        ir_m  = 0;
        cur = mk(1,0,0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        foreach (vl[i]) begin
            #1;
            CLR = vl[i].clr; FRLd = vl[i].frld; IRLd = vl[i].irld;
            A = vl[i].a; B = vl[i].b; OP = vl[i].op; CIN = vl[i].cin;
            IR_IN = vl[i].ir_in;
            e = alu_model(vl[i].a, vl[i].b, vl[i].op, vl[i].cin);
            e.fdr = fdr_m;
            e.ir  = ir_m;
            exp_q.push_back(e);
            @(posedge CLK);
            if (vl[i].clr) begin
                fdr_m = 0;
                ir_m  = 0;
            end else begin
                if (vl[i].frld) fdr_m = e.flags;
                if (vl[i].irld) ir_m  = vl[i].ir_in;
            end
        end
        drive_done = 1;
    end

    // Monitor: outputs are presented every cycle; check mid-cycle.
    initial begin : monitor
        exp_t e;
        int   idle;
        idle = 0;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                idle = 0;
                if (RESULT !== e.res) begin
                    n_bad++;
                    $display("FAIL result vec %0d: got %h want %h", n_vec, RESULT, e.res);
                end
                if ({FLAG_N, FLAG_Z, FLAG_C, FLAG_V} !== e.flags) begin
                    n_bad++;
                    $display("FAIL flags vec %0d: got %b want %b", n_vec,
                             {FLAG_N, FLAG_Z, FLAG_C, FLAG_V}, e.flags);
                end
                if (FDR_OUT !== e.fdr) begin
                    n_bad++;
                    $display("FAIL fdr vec %0d: got %b want %b", n_vec, FDR_OUT, e.fdr);
                end
                if (IR_OUT !== e.ir) begin
                    n_bad++;
                    $display("FAIL ir vec %0d: got %h want %h", n_vec, IR_OUT, e.ir);
                end
            end else if (drive_done) begin
                break;
            end else begin
                idle++;
                if (idle > 100) begin
                    n_bad++;
                    $display("FAIL timeout: no vectors for %0d cycles, want activity", idle);
                    break;
                end
            end
        end
        if (n_vec < 12) begin
            n_bad++;
            $display("FAIL vec_count: got %0d want >= 12", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_fdr_ir.md
# alu_fdr_ir

Execute-stage slice of the CPU datapath. It holds a combinational 32-bit ALU with ARM-style data-processing opcodes plus control-unit auxiliary opcodes, and a 4-bit flag register (FDR) that captures the ALU's N/Z/C/V on command. It also holds the 32-bit instruction register (IR) that latches memory read data. ALU result feeds the register file and MAR; IR and flag outputs feed the control unit and the condition tester.

## Interface
- No parameters; all widths fixed.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR  in  1  reset, synchronous, active-high; clears FDR and IR.
- A  in  32  ALU operand A (register-file port A).
- B  in  32  ALU operand B (mux B output).
- OP  in  5  ALU operation select.
- CIN  in  1  carry-in for ADC/SBC/RSC.
- FRLd  in  1  flag register load enable.
- IRLd  in  1  instruction register load enable.
- IR_IN  in  32  memory data-out to be latched into IR.
- RESULT  out  32  ALU result, combinational.
- FLAG_N, FLAG_Z, FLAG_C, FLAG_V  out  1 each  live ALU flags, combinational.
- FDR_OUT  out  4  registered flags, order {N,Z,C,V}.
- IR_OUT  out  32  registered instruction.

## Operation
- ALU opcodes, with C = carry out and subtraction carry = NOT borrow:
  - 00000 AND: A&B.
  - 00001 EOR: A^B.
  - 00010 SUB: A−B.
  - 00011 RSB: B−A.
  - 00100 ADD: A+B.
  - 00101 ADC: A+B+CIN.
  - 00110 SBC: A−B−!CIN.
  - 00111 RSC: B−A−!CIN.
  - 01000 TST: A&B.
  - 01001 TEQ: A^B.
  - 01010 CMP: A−B.
  - 01011 CMN: A+B.
  - 01100 ORR: A|B.
  - 01101 MOV: B.
  - 01110 BIC: A&~B.
  - 01111 MVN: ~B.
- Auxiliary opcodes:
  - 10000: A+4 (PC increment).
  - 10001: A+B+4.
  - 10010: A+B.
  - 10011: pass A.
  - 10100: pass B.
  - 10101–11111: pass B.
- TST/TEQ/CMP/CMN drive RESULT normally. Suppressing register writeback is the control unit's job.
- Flag rules:
  - N = RESULT[31]; Z = (RESULT==0).
  - Arithmetic ops (all add/subtract forms, including auxiliary adds): C = 33rd bit of unsigned add (for subtract, computed as A+~B+1 style); V = signed overflow (operands same sign, result sign differs).
  - Logical and pass ops: C = CIN, V = 0.
- FDR: on rising CLK, if CLR then FDR_OUT=0000; else if FRLd then FDR_OUT={FLAG_N,FLAG_Z,FLAG_C,FLAG_V}; else hold.
- IR: on rising CLK, if CLR then IR_OUT=0; else if IRLd then IR_OUT=IR_IN; else hold.
- CLR has priority over FRLd/IRLd when asserted together.

## Timing
- ALU: zero latency, purely combinational from A/B/OP/CIN.
- FDR and IR: one-cycle latency; new value visible after the loading edge.
- Reset values: FDR_OUT=4'b0000, IR_OUT=32'h0. RESULT/flags follow inputs and are not reset.
- Reset mid-operation: CLR on any edge overrides the pending load in that cycle.
- Load with unchanged inputs is idempotent; load enable held high reloads every cycle.
- No handshake; the control unit sequences FRLd/IRLd.

## Test plan
- Reset: CLR=1 for one edge with FRLd=IRLd=1 and nonzero inputs -> FDR_OUT=0000, IR_OUT=0.
- ADD overflow: A=7FFFFFFF, B=00000001, OP=00100, FRLd=1 -> RESULT=80000000, after edge FDR_OUT=1001 (N=1,Z=0,C=0,V=1).
- CMP equal: A=B=00000005, OP=01010 -> RESULT=0, live flags N0 Z1 C1 V0; FRLd=0 -> FDR_OUT unchanged.
- ADC/SBC carry-in: A=FFFFFFFF, B=0, CIN=1, OP=00101 -> RESULT=0, C=1, Z=1. A=5, B=3, CIN=0, OP=00110 -> RESULT=1, C=1.
- Logic/aux ops: A=F0F0F0F0, B=FF00FF00, OP=01110 (BIC) -> 00F000F0. OP=01111 (MVN) -> 00FF00FF. OP=10000 with A=00000010 -> 00000014. For logic ops C=CIN and V=0.
- IR: IR_IN=E2811001, IRLd=1 -> IR_OUT=E2811001 after the edge. IRLd=0 with IR_IN changed -> IR_OUT holds.
